// File: rtl/rs_cmd_ctrl_pkg.sv
// Shared definitions for the RS flip-flop command controller:
// FSM state encoding, default parameter values and the request arbitration rule.
package rs_cmd_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_DRIVE   = 2'd1,
    ST_WAIT_FB = 2'd2,
    ST_ERROR   = 2'd3
  } state_e;

  localparam int unsigned DEF_DEB_CYCLES = 4;
  localparam int unsigned DEF_TIMEOUT    = 8;
  localparam int unsigned DEF_CNT_W      = 8;

  // A reset request beats a simultaneous set request, so the target is simply !rst_req.
  function automatic logic req_target(input logic rst_req);
    return ~rst_req;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Push-button conditioner: 2-flop synchroniser, stability-count debounce
// and a registered one-cycle pulse on each rising edge of the debounced level.
module btn_debounce #(
  parameter int unsigned DEB_CYCLES = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_i,
  output logic rise_o
);

  localparam int unsigned CW = (DEB_CYCLES < 2) ? 1 : $clog2(DEB_CYCLES + 1);

  logic          sync1_q, sync2_q;
  logic          level_q, level_d;
  logic          rise_q, rise_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // The DEB_CYCLES-th consecutive differing sample flips the level.
  always_comb begin
    cnt_d   = cnt_q;
    level_d = level_q;
    rise_d  = 1'b0;
    if (sync2_q != level_q) begin
      if (cnt_q == CW'(DEB_CYCLES - 1)) begin
        level_d = ~level_q;
        cnt_d   = '0;
        rise_d  = ~level_q;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end else begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      cnt_q   <= '0;
      rise_q  <= 1'b0;
    end else begin
      sync1_q <= btn_i;
      sync2_q <= sync1_q;
      level_q <= level_d;
      cnt_q   <= cnt_d;
      rise_q  <= rise_d;
    end
  end

  assign rise_o = rise_q;

endmodule

// File: rtl/rs_cmd_ctrl.sv
// Command controller for a clocked RS flip-flop: turns debounced button presses
// into single-cycle S/R pulses, confirms them against q_fb and counts completions.
//
// state   | meaning
// IDLE    | waiting for a request; no-op if q_fb already equals the target
// DRIVE   | one cycle with S or R high
// WAIT_FB | waiting for q_fb to reach the target, bounded by TIMEOUT
// ERROR   | sticky timeout; only rst_n leaves
module rs_cmd_ctrl
  import rs_cmd_ctrl_pkg::*;
#(
  parameter int unsigned DEB_CYCLES = DEF_DEB_CYCLES,
  parameter int unsigned TIMEOUT    = DEF_TIMEOUT,
  parameter int unsigned CNT_W      = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             set_btn,
  input  logic             rst_btn,
  input  logic             q_fb,
  output logic             S,
  output logic             R,
  output logic             busy,
  output logic             err,
  output logic [CNT_W-1:0] cmd_cnt
);

  localparam int unsigned TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  logic set_req, rst_req, req_tgt;

  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_set_deb (
    .clk    (clk),
    .rst_n  (rst_n),
    .btn_i  (set_btn),
    .rise_o (set_req)
  );

  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_rst_deb (
    .clk    (clk),
    .rst_n  (rst_n),
    .btn_i  (rst_btn),
    .rise_o (rst_req)
  );

  assign req_tgt = req_target(rst_req);

  state_e           state_q;
  logic             target_q;
  logic [TW-1:0]    tmo_q;
  logic             s_q, r_q, busy_q, err_q;
  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      target_q <= 1'b0;
      tmo_q    <= '0;
      s_q      <= 1'b0;
      r_q      <= 1'b0;
      busy_q   <= 1'b0;
      err_q    <= 1'b0;
      cnt_q    <= '0;
    end else begin
      s_q <= 1'b0;
      r_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if ((set_req || rst_req) && (req_tgt != q_fb)) begin
            target_q <= req_tgt;
            state_q  <= ST_DRIVE;
            busy_q   <= 1'b1;
            s_q      <= req_tgt;
            r_q      <= ~req_tgt;
          end
        end
        ST_DRIVE: begin
          state_q <= ST_WAIT_FB;
          tmo_q   <= '0;
        end
        ST_WAIT_FB: begin
          if (q_fb == target_q) begin
            cnt_q   <= cnt_q + CNT_W'(1);
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end else if (tmo_q == TW'(TIMEOUT - 1)) begin
            state_q <= ST_ERROR;
            err_q   <= 1'b1;
            busy_q  <= 1'b0;
          end else begin
            tmo_q <= tmo_q + TW'(1);
          end
        end
        ST_ERROR: begin
          err_q  <= 1'b1;
          busy_q <= 1'b0;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign S       = s_q;
  assign R       = r_q;
  assign busy    = busy_q;
  assign err     = err_q;
  assign cmd_cnt = cnt_q;

endmodule

// File: tb/tb_rs_cmd_ctrl.sv
// Self-checking bench for rs_cmd_ctrl: directed scenarios plus randomized presses
// scored against a press-level model of the controller and the downstream flip-flop.
module tb_rs_cmd_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       set_btn = 1'b0;
  logic       rst_btn = 1'b0;
  logic       q_fb = 1'b0;
  logic       S, R, busy, err;
  logic [7:0] cmd_cnt;

  always #5 clk = ~clk;

  rs_cmd_ctrl dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .set_btn (set_btn),
    .rst_btn (rst_btn),
    .q_fb    (q_fb),
    .S       (S),
    .R       (R),
    .busy    (busy),
    .err     (err),
    .cmd_cnt (cmd_cnt)
  );

  int n_chk = 0;
  int n_pass = 0;

  // Model: flip-flop state, sticky error and completed-command count.
  bit m_q = 1'b0;
  bit m_err = 1'b0;
  int m_cnt = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic set_q(input bit v);
    q_fb = v;
    m_q  = v;
  endtask

  task automatic apply_reset(input int cycles);
    rst_n = 1'b0;
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk); #1;
      set_btn = 1'($urandom_range(0, 1));
      rst_btn = 1'($urandom_range(0, 1));
      @(negedge clk);
      chk("rst_outs", {S, R, busy, err, cmd_cnt}, 0);
    end
    set_btn = 1'b0;
    rst_btn = 1'b0;
    rst_n   = 1'b1;
    m_err   = 1'b0;
    m_cnt   = 0;
    repeat (8) @(negedge clk);
    chk("post_rst_outs", {S, R, busy, err, cmd_cnt}, 0);
  endtask

  // One press: optional short glitch, then a clean hold of `hold` cycles.
  // Expected pulse timing: 7 edges after the clean press starts; timeout error 16 edges after.
  task automatic run_cmd(input bit ds, input bit dr, input int glitch, input int hold,
                         input bit respond, input string tag);
    bit tgt, exp_p, both, fb_pend, fb_val, busy8;
    int s_n, r_n, s_k, r_k, err_k;
    tgt = dr ? 1'b0 : 1'b1;
    exp_p = !m_err && (tgt != m_q);
    s_n = 0; r_n = 0; s_k = -1; r_k = -1; err_k = -1;
    both = 0; fb_pend = 0; fb_val = 0; busy8 = 0;
    @(posedge clk); #1;
    if (glitch > 0) begin
      set_btn = ds;
      rst_btn = dr;
      for (int k = 1; k <= glitch + 10; k++) begin
        @(posedge clk); #1;
        if (k == glitch) begin
          set_btn = 1'b0;
          rst_btn = 1'b0;
        end
        @(negedge clk);
        if (S) s_n++;
        if (R) r_n++;
      end
      chk({tag, "_glitch_pulses"}, s_n + r_n, 0);
      @(posedge clk); #1;
    end
    set_btn = ds;
    rst_btn = dr;
    for (int k = 1; k <= 24; k++) begin
      @(posedge clk); #1;
      if (fb_pend) begin
        q_fb = fb_val;
        fb_pend = 0;
      end
      if (k == hold) begin
        set_btn = 1'b0;
        rst_btn = 1'b0;
      end
      @(negedge clk);
      if (S) begin s_n++; s_k = k; if (respond) begin fb_pend = 1; fb_val = 1; end end
      if (R) begin r_n++; r_k = k; if (respond) begin fb_pend = 1; fb_val = 0; end end
      if (S && R) both = 1;
      if (err && err_k < 0) err_k = k;
      if (k == 8) busy8 = busy;
    end
    chk({tag, "_s_pulses"}, s_n, (exp_p && tgt) ? 1 : 0);
    chk({tag, "_r_pulses"}, r_n, (exp_p && !tgt) ? 1 : 0);
    chk({tag, "_s_and_r"}, both, 0);
    chk({tag, "_busy_k8"}, busy8, exp_p);
    if (exp_p) begin
      chk({tag, "_pulse_cycle"}, tgt ? s_k : r_k, 7);
      if (respond) begin
        m_q = tgt;
        m_cnt = (m_cnt + 1) % 256;
      end else begin
        m_err = 1'b1;
        chk({tag, "_err_cycle"}, err_k, 16);
      end
    end
    chk({tag, "_cmd_cnt"}, cmd_cnt, m_cnt);
    chk({tag, "_err"}, err, m_err);
    chk({tag, "_busy_end"}, busy, 0);
  endtask

  task automatic abort_test();
    int pulses;
    set_q(1'b0);
    @(posedge clk); #1;
    set_btn = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      @(posedge clk); #1;
      @(negedge clk);
    end
    chk("abort_busy_before", busy, 1);
    rst_n = 1'b0;
    set_btn = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    chk("abort_busy_after", busy, 0);
    chk("abort_sr_after", {S, R}, 0);
    rst_n = 1'b1;
    m_err = 1'b0;
    m_cnt = 0;
    pulses = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (S || R) pulses++;
    end
    chk("abort_no_pulse", pulses, 0);
    chk("abort_cmd_cnt", cmd_cnt, m_cnt);
  endtask

  initial begin
    int guard;
    bit ds, dr;
    apply_reset(3);

    set_q(1'b0);
    run_cmd(1, 0, 0, 6, 1, "clean_set");

    set_q(1'b0);
    run_cmd(1, 0, 3, 5, 1, "bounce_set");

    set_q(1'b1);
    run_cmd(1, 1, 0, 6, 1, "conflict");
    run_cmd(1, 0, 0, 6, 1, "set_after");
    run_cmd(1, 0, 0, 6, 1, "noop");

    set_q(1'b0);
    run_cmd(1, 0, 0, 6, 0, "timeout");
    set_q(1'b1);
    run_cmd(0, 1, 0, 6, 1, "err_drop");
    apply_reset(3);

    for (int t = 0; t < 40; t++) begin
      case ($urandom_range(0, 2))
        0: begin ds = 1; dr = 0; end
        1: begin ds = 0; dr = 1; end
        default: begin ds = 1; dr = 1; end
      endcase
      if ($urandom_range(0, 7) == 0) set_q(~m_q);
      run_cmd(ds, dr, int'($urandom_range(0, 3)), int'($urandom_range(4, 8)),
              $urandom_range(0, 11) != 0, "rand");
      if (m_err && $urandom_range(0, 1) == 0) apply_reset(2);
    end

    apply_reset(2);
    guard = 0;
    while (m_cnt != 255 && guard < 400) begin
      if (m_q) begin ds = 1'($urandom_range(0, 1)); dr = 1; end
      else begin ds = 1; dr = 0; end
      run_cmd(ds, dr, int'($urandom_range(0, 2)), int'($urandom_range(4, 6)), 1, "fill");
      guard++;
    end
    chk("fill_reached_255", cmd_cnt, 255);
    run_cmd(!m_q, m_q, 0, 5, 1, "wrap");
    chk("wrap_to_zero", cmd_cnt, 0);

    abort_test();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
